// File: rtl/rob_nch_pkg.sv
// Shared ROB types: entry status, instruction class and the stored entry record.
package rob_nch_pkg;

  localparam int ROB_DEPTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    empty    = 2'b00,
    rob_wait = 2'b01,
    done     = 2'b10
  } status_t;

  typedef enum logic [2:0] {
    op_alu, op_alu_imm, op_load, op_store, op_branch, op_jal, op_jalr, op_lui
  } types_t;

  // rd_rob_idx is wide enough for the largest supported depth (64).
  typedef struct packed {
    logic        valid;
    status_t     status;
    types_t      op_type;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [5:0]  rd_rob_idx;
  } rob_entry_t;

endpackage

// File: rtl/rob_wb_select.sv
// Priority match of one ROB index against all CDB writeback channels; lowest channel wins.
module rob_wb_select #(
  parameter int NUM_WB = 2,
  parameter int IDX_W  = 5
) (
  input  logic [IDX_W-1:0]       idx,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] wb_rob_idx,
  input  logic [NUM_WB*32-1:0]   wb_data,
  output logic                   hit,
  output logic [31:0]            data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int c = NUM_WB - 1; c >= 0; c--) begin
      if (wb_valid[c] && (wb_rob_idx[c*IDX_W +: IDX_W] == idx)) begin
        hit  = 1'b1;
        data = wb_data[c*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/rob_nch.sv
// Parametrised reorder buffer: in-order allocate/commit, NUM_WB writeback channels, NUM_LOOKUP operand ports.
// Optional macro ROB_BYPASS_EN forwards same-cycle writeback data onto the lookup ports.
module rob_nch
  import rob_nch_pkg::*;
#(
  parameter int DEPTH      = ROB_DEPTH_DEFAULT,
  parameter int NUM_WB     = 2,
  parameter int NUM_LOOKUP = 2,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        dis_valid,
  input  logic [2:0]                  dis_op_type,
  input  logic [4:0]                  dis_rd_addr,
  output logic                        dis_ready,
  output logic [IDX_W-1:0]            dis_rob_idx,
  input  logic [NUM_WB-1:0]           wb_valid,
  input  logic [NUM_WB*IDX_W-1:0]     wb_rob_idx,
  input  logic [NUM_WB*32-1:0]        wb_data,
  input  logic [NUM_LOOKUP*IDX_W-1:0] lk_idx,
  output logic [NUM_LOOKUP-1:0]       lk_ready,
  output logic [NUM_LOOKUP*32-1:0]    lk_data,
  output logic                        commit_valid,
  output logic                        commit_regf_we,
  output logic [4:0]                  commit_rd_addr,
  output logic [IDX_W-1:0]            commit_rob_idx,
  output logic [31:0]                 commit_data,
  output logic                        rob_empty
);

  localparam logic [IDX_W:0] PTR_ONE = 1;

  rob_entry_t       entries [DEPTH];
  logic [IDX_W:0]   head, tail;
  logic             full, dis_fire, commit_fire;
  rob_entry_t       head_ent;
  logic [DEPTH-1:0] wb_hit, wb_en;
  logic [31:0]      wb_sel_data [DEPTH];

  // Pointers carry a wrap bit: equal low bits with differing MSB means full.
  assign full        = (head[IDX_W] != tail[IDX_W]) && (head[IDX_W-1:0] == tail[IDX_W-1:0]);
  assign rob_empty   = (head == tail);
  assign dis_ready   = !full;
  assign dis_rob_idx = tail[IDX_W-1:0];
  assign dis_fire    = dis_valid && !full;

  assign head_ent    = entries[head[IDX_W-1:0]];
  assign commit_fire = head_ent.valid && (head_ent.status == done);

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    rob_wb_select #(.NUM_WB(NUM_WB), .IDX_W(IDX_W)) u_sel (
      .idx        (IDX_W'(e)),
      .wb_valid   (wb_valid),
      .wb_rob_idx (wb_rob_idx),
      .wb_data    (wb_data),
      .hit        (wb_hit[e]),
      .data       (wb_sel_data[e])
    );
    assign wb_en[e] = wb_hit[e] && entries[e].valid && (entries[e].status == rob_wait);
  end

  for (genvar p = 0; p < NUM_LOOKUP; p++) begin : g_lookup
    rob_entry_t lk_ent;
    logic       lk_stored;
    assign lk_ent    = entries[lk_idx[p*IDX_W +: IDX_W]];
    assign lk_stored = lk_ent.valid && (lk_ent.status == done);
`ifdef ROB_BYPASS_EN
    logic        byp_hit, byp_ok;
    logic [31:0] byp_data;
    rob_wb_select #(.NUM_WB(NUM_WB), .IDX_W(IDX_W)) u_byp (
      .idx        (lk_idx[p*IDX_W +: IDX_W]),
      .wb_valid   (wb_valid),
      .wb_rob_idx (wb_rob_idx),
      .wb_data    (wb_data),
      .hit        (byp_hit),
      .data       (byp_data)
    );
    assign byp_ok               = byp_hit && lk_ent.valid && (lk_ent.status == rob_wait);
    assign lk_ready[p]          = lk_stored || byp_ok;
    assign lk_data[p*32 +: 32]  = byp_ok ? byp_data : lk_ent.rd_data;
`else
    assign lk_ready[p]          = lk_stored;
    assign lk_data[p*32 +: 32]  = lk_ent.rd_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        entries[e].valid  <= 1'b0;
        entries[e].status <= empty;
      end
      head           <= '0;
      tail           <= '0;
      commit_valid   <= 1'b0;
      commit_regf_we <= 1'b0;
      commit_rd_addr <= '0;
      commit_rob_idx <= '0;
      commit_data    <= '0;
    end else if (flush) begin
      for (int e = 0; e < DEPTH; e++) begin
        entries[e].valid  <= 1'b0;
        entries[e].status <= empty;
      end
      head           <= '0;
      tail           <= '0;
      commit_valid   <= 1'b0;
      commit_regf_we <= 1'b0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (wb_en[e]) begin
          entries[e].rd_data <= wb_sel_data[e];
          entries[e].status  <= done;
        end
      end
      // Commit frees the head slot only from the next cycle on; dis_ready ignores it.
      if (commit_fire) begin
        commit_valid   <= 1'b1;
        commit_regf_we <= (head_ent.rd_addr != 5'd0);
        commit_rd_addr <= head_ent.rd_addr;
        commit_rob_idx <= head_ent.rd_rob_idx[IDX_W-1:0];
        commit_data    <= head_ent.rd_data;
        entries[head[IDX_W-1:0]].valid  <= 1'b0;
        entries[head[IDX_W-1:0]].status <= empty;
        head <= head + PTR_ONE;
      end else begin
        commit_valid   <= 1'b0;
        commit_regf_we <= 1'b0;
      end
      if (dis_fire) begin
        entries[tail[IDX_W-1:0]] <= '{valid: 1'b1, status: rob_wait,
                                      op_type: types_t'(dis_op_type),
                                      rd_addr: dis_rd_addr, rd_data: 32'd0,
                                      rd_rob_idx: 6'(tail[IDX_W-1:0])};
        tail <= tail + PTR_ONE;
      end
    end
  end

endmodule
